// File: rtl/boom_dcache_line_reader.sv
// Streams one 64-byte line from the L1 data array as eight 64-bit beats.
// Credits bound outstanding reads plus buffered beats so that responses, which cannot be stalled,
// always have room in the beat FIFO.
module boom_dcache_line_reader #(
  parameter int unsigned WAYS         = 8,
  parameter int unsigned BEATS        = 8,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned BUF_DEPTH    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_req_valid,
  output logic                     io_req_ready,
  input  logic [WAYS-1:0]          io_req_bits_way_en,
  input  logic [5:0]               io_req_bits_idx,
  output logic                     io_data_read_valid,
  input  logic                     io_data_read_ready,
  output logic [WAYS-1:0]          io_data_read_bits_way_en,
  output logic [11:0]              io_data_read_bits_addr,
  input  logic [64*WAYS-1:0]       io_data_resp,
  output logic                     io_beat_valid,
  input  logic                     io_beat_ready,
  output logic [63:0]              io_beat_bits_data,
  output logic [$clog2(BEATS)-1:0] io_beat_bits_beat,
  output logic                     io_beat_bits_last,
  output logic                     io_busy
);

  localparam int unsigned BeatW = $clog2(BEATS);
  localparam int unsigned CredW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PtrW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);
  localparam logic [CredW-1:0] CredMax  = CredW'(BUF_DEPTH);
  localparam logic [PtrW-1:0]  PtrMax   = PtrW'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [WAYS-1:0]         way_q, way_d;
  logic [5:0]              idx_q, idx_d;
  logic [BeatW-1:0]        issue_q, issue_d;
  logic [CredW-1:0]        cred_q, cred_d;
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [BeatW-1:0]        pipe_beat_q [READ_LATENCY];
  logic [BeatW-1:0]        pipe_beat_d [READ_LATENCY];
  logic [63:0]             mem_data_q [BUF_DEPTH];
  logic [BeatW-1:0]        mem_beat_q [BUF_DEPTH];
  logic [PtrW-1:0]         head_q, head_d;
  logic [PtrW-1:0]         tail_q, tail_d;
  logic [CredW-1:0]        cnt_q, cnt_d;

  logic        req_fire;
  logic        read_fire;
  logic        beat_fire;
  logic        push;
  logic [63:0] resp_sel;

  assign io_req_ready             = (state_q == StIdle) && reset;
  assign io_busy                  = (state_q != StIdle);
  assign io_data_read_valid       = (state_q == StIssue) && (cred_q < CredMax);
  assign io_data_read_bits_way_en = way_q;
  assign io_data_read_bits_addr   = {idx_q, issue_q, 3'b000};

  assign io_beat_valid     = (cnt_q != '0);
  assign io_beat_bits_data = mem_data_q[head_q];
  assign io_beat_bits_beat = mem_beat_q[head_q];
  assign io_beat_bits_last = (mem_beat_q[head_q] == LastBeat);

  assign req_fire  = io_req_valid && io_req_ready;
  assign read_fire = io_data_read_valid && io_data_read_ready;
  assign beat_fire = io_beat_valid && io_beat_ready;
  assign push      = pipe_vld_q[READ_LATENCY-1];

  // Multi-hot way_en ORs the selected ways; zero way_en yields zero data.
  always_comb begin
    resp_sel = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_q[w]) resp_sel = resp_sel | io_data_resp[64*w +: 64];
    end
  end

  always_comb begin
    state_d = state_q;
    way_d   = way_q;
    idx_d   = idx_q;
    issue_d = issue_q;
    unique case (state_q)
      StIdle: begin
        if (req_fire) begin
          way_d   = io_req_bits_way_en;
          idx_d   = io_req_bits_idx;
          issue_d = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (read_fire) begin
          issue_d = issue_q + BeatW'(1);
          if (issue_q == LastBeat) state_d = StDrain;
        end
      end
      StDrain: begin
        if (beat_fire && io_beat_bits_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cred_d         = cred_q + CredW'(read_fire) - CredW'(beat_fire);
    pipe_vld_d     = '0;
    pipe_vld_d[0]  = read_fire;
    pipe_beat_d[0] = issue_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_beat_d[i] = pipe_beat_q[i-1];
    end
    tail_d = tail_q;
    if (push) tail_d = (tail_q == PtrMax) ? '0 : tail_q + PtrW'(1);
    head_d = head_q;
    if (beat_fire) head_d = (head_q == PtrMax) ? '0 : head_q + PtrW'(1);
    cnt_d = cnt_q + CredW'(push) - CredW'(beat_fire);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      way_q      <= '0;
      idx_q      <= '0;
      issue_q    <= '0;
      cred_q     <= '0;
      pipe_vld_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      way_q      <= way_d;
      idx_q      <= idx_d;
      issue_q    <= issue_d;
      cred_q     <= cred_d;
      pipe_vld_q <= pipe_vld_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
    end
  end

  // Payload storage needs no reset: the valid bits and FIFO count gate it.
  always_ff @(posedge clock) begin
    for (int i = 0; i < READ_LATENCY; i++) pipe_beat_q[i] <= pipe_beat_d[i];
    if (push) begin
      mem_data_q[tail_q] <= resp_sel;
      mem_beat_q[tail_q] <= pipe_beat_q[READ_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_boom_dcache_line_reader.sv
// Directed bench for boom_dcache_line_reader with a 2-cycle registered data-array model.
module tb_boom_dcache_line_reader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [7:0]   req_way;
  logic [5:0]   req_idx;
  logic         read_valid;
  logic         read_ready;
  logic [7:0]   read_way;
  logic [11:0]  read_addr;
  logic [511:0] resp;
  logic         beat_valid;
  logic         beat_ready;
  logic [63:0]  beat_data;
  logic [2:0]   beat_idx;
  logic         beat_last;
  logic         busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  boom_dcache_line_reader dut (
    .clock                    (clk),
    .reset                    (rst_n),
    .io_req_valid             (req_valid),
    .io_req_ready             (req_ready),
    .io_req_bits_way_en       (req_way),
    .io_req_bits_idx          (req_idx),
    .io_data_read_valid       (read_valid),
    .io_data_read_ready       (read_ready),
    .io_data_read_bits_way_en (read_way),
    .io_data_read_bits_addr   (read_addr),
    .io_data_resp             (resp),
    .io_beat_valid            (beat_valid),
    .io_beat_ready            (beat_ready),
    .io_beat_bits_data        (beat_data),
    .io_beat_bits_beat        (beat_idx),
    .io_beat_bits_last        (beat_last),
    .io_busy                  (busy)
  );

  function automatic logic [63:0] way_data(input int w, input logic [11:0] a);
    return {8'(w + 1), 8'h5A, 4'h0, 4'(w), 28'h0, a};
  endfunction

  function automatic logic [63:0] exp_beat(input logic [7:0] way, input logic [5:0] idx,
                                           input int b);
    logic [63:0] d;
    logic [2:0]  bb;
    d  = '0;
    bb = 3'(b);
    for (int w = 0; w < 8; w++) if (way[w]) d = d | way_data(w, {idx, bb, 3'b000});
    return d;
  endfunction

  // Array model: address registered twice, response valid READ_LATENCY cycles after the fire.
  logic [11:0] m_a0 = '0;
  logic [11:0] m_a1 = '0;
  always @(posedge clk) begin
    m_a0 <= read_addr;
    m_a1 <= m_a0;
  end
  always_comb begin
    resp = '0;
    for (int w = 0; w < 8; w++) resp[64*w +: 64] = way_data(w, m_a1);
  end

  logic [11:0] rd_addr [16];
  logic [7:0]  rd_way  [16];
  int          rd_cyc  [16];
  int          n_rd;
  logic [63:0] bt_data [16];
  logic [2:0]  bt_beat [16];
  logic        bt_last [16];
  int          bt_cyc  [16];
  int          n_bt;
  int          n_rd_at_hold;
  logic        rv_before_release;
  logic        bv_before_release;
  int          addr_jump;
  int          valid_drop;
  int          beat_unstable;
  int          early_accept;
  logic        req_acc;
  logic        ready_at_last;
  logic        ready_after;
  int          last_k;

  // Drives one line request and records every read and beat handshake; k=0 is the request cycle.
  task automatic stream_line(input logic [7:0] way, input logic [5:0] idx, input int rd_mode,
                             input int bt_mode, input int hold, input bit no_wait,
                             input bit chain, input logic [7:0] nway, input logic [5:0] nidx);
    int          k;
    logic        pend;
    logic [11:0] paddr;
    logic        held;
    logic [63:0] hdata;
    logic [2:0]  hbeat;
    n_rd = 0; n_bt = 0; addr_jump = 0; valid_drop = 0; beat_unstable = 0; early_accept = 0;
    n_rd_at_hold = -1; pend = 1'b0; held = 1'b0; k = 0; paddr = '0; hdata = '0; hbeat = '0;
    rv_before_release = 1'bx; bv_before_release = 1'bx; ready_at_last = 1'bx; last_k = -100;
    if (!no_wait) @(negedge clk);
    req_valid = 1'b1; req_way = way; req_idx = idx;
    while (n_bt < 8 && k < 200) begin
      if (k == 1) begin
        req_valid = chain; req_way = nway; req_idx = nidx;
      end
      read_ready = (rd_mode == 0) ? 1'b1 : ((k % 3) == 1);
      beat_ready = (bt_mode == 0) || (k >= hold);
      #1;
      if (k == 0) req_acc = req_ready;
      else if (req_ready && req_valid) early_accept++;
      if (k == hold) n_rd_at_hold = n_rd;
      if (k == hold - 1) begin
        rv_before_release = read_valid; bv_before_release = beat_valid;
      end
      if (pend && !read_valid) valid_drop++;
      if (read_valid) begin
        if (pend && read_addr !== paddr) addr_jump++;
        if (read_ready) begin
          if (n_rd < 16) begin
            rd_addr[n_rd] = read_addr; rd_way[n_rd] = read_way; rd_cyc[n_rd] = k;
          end
          n_rd++; pend = 1'b0;
        end else begin
          pend = 1'b1; paddr = read_addr;
        end
      end
      if (beat_valid) begin
        if (held && (beat_data !== hdata || beat_idx !== hbeat)) beat_unstable++;
        if (beat_ready) begin
          bt_data[n_bt] = beat_data; bt_beat[n_bt] = beat_idx; bt_last[n_bt] = beat_last;
          bt_cyc[n_bt] = k; ready_at_last = req_ready; last_k = k;
          n_bt++; held = 1'b0;
        end else begin
          held = 1'b1; hdata = beat_data; hbeat = beat_idx;
        end
      end
      if (n_bt < 8) begin
        @(negedge clk);
        k++;
      end
    end
    @(negedge clk);
    #1;
    ready_after = req_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_way = '0; req_idx = '0;
    read_ready = 1'b1; beat_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (read_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_read_valid: got %b expected 0", read_valid);
    end
    tests_run++;
    if (beat_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_beat_valid: got %b expected 0", beat_valid);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_req_ready_low: got %b expected 0", req_ready);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_req_ready_high: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_basic();
    stream_line(8'h04, 6'h15, 0, 0, 0, 1'b0, 1'b0, 8'h00, 6'h00);
    tests_run++;
    if (n_rd !== 8 || n_bt !== 8) begin
      tests_failed++; $display("FAIL basic_counts: got %0d reads %0d beats expected 8 8", n_rd, n_bt);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (rd_addr[i] !== 12'h540 + 12'(8 * i) || rd_cyc[i] !== i + 1 || rd_way[i] !== 8'h04) begin
        tests_failed++;
        $display("FAIL basic_read%0d: got addr %h cyc %0d way %h expected addr %h cyc %0d way 04",
                 i, rd_addr[i], rd_cyc[i], rd_way[i], 12'h540 + 12'(8 * i), i + 1);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (bt_data[i] !== exp_beat(8'h04, 6'h15, i) || bt_beat[i] !== 3'(i) ||
          bt_last[i] !== (i == 7) || bt_cyc[i] !== i + 4) begin
        tests_failed++;
        $display("FAIL basic_beat%0d: got %h/%0d/%b cyc %0d expected %h/%0d/%b cyc %0d", i,
                 bt_data[i], bt_beat[i], bt_last[i], bt_cyc[i], exp_beat(8'h04, 6'h15, i), i,
                 (i == 7), i + 4);
      end
    end
    tests_run++;
    if (bt_cyc[0] - rd_cyc[0] !== 3) begin
      tests_failed++;
      $display("FAIL basic_first_latency: got %0d expected 3", bt_cyc[0] - rd_cyc[0]);
    end
    tests_run++;
    if (ready_at_last !== 1'b0 || ready_after !== 1'b1 || last_k + 1 !== 12) begin
      tests_failed++;
      $display("FAIL basic_req_ready_return: got last %b after %b at %0d expected 0 1 at 12",
               ready_at_last, ready_after, last_k + 1);
    end
  endtask

  task automatic test_backpressure();
    stream_line(8'h40, 6'h0A, 0, 1, 12, 1'b0, 1'b0, 8'h00, 6'h00);
    tests_run++;
    if (n_rd_at_hold !== 4) begin
      tests_failed++; $display("FAIL bp_reads_held: got %0d expected 4", n_rd_at_hold);
    end
    tests_run++;
    if (rv_before_release !== 1'b0 || bv_before_release !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_valids_held: got read %b beat %b expected 0 1", rv_before_release,
               bv_before_release);
    end
    tests_run++;
    if (beat_unstable !== 0) begin
      tests_failed++; $display("FAIL bp_beat_stable: got %0d changes expected 0", beat_unstable);
    end
    tests_run++;
    if (n_rd !== 8 || n_bt !== 8) begin
      tests_failed++; $display("FAIL bp_counts: got %0d reads %0d beats expected 8 8", n_rd, n_bt);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (bt_data[i] !== exp_beat(8'h40, 6'h0A, i) || bt_beat[i] !== 3'(i) ||
          bt_last[i] !== (i == 7)) begin
        tests_failed++;
        $display("FAIL bp_beat%0d: got %h/%0d/%b expected %h/%0d/%b", i, bt_data[i], bt_beat[i],
                 bt_last[i], exp_beat(8'h40, 6'h0A, i), i, (i == 7));
      end
    end
  endtask

  task automatic test_read_toggle();
    stream_line(8'h08, 6'h3C, 1, 0, 0, 1'b0, 1'b0, 8'h00, 6'h00);
    tests_run++;
    if (n_rd !== 8 || addr_jump !== 0 || valid_drop !== 0) begin
      tests_failed++;
      $display("FAIL toggle_handshake: got %0d reads %0d jumps %0d drops expected 8 0 0", n_rd,
               addr_jump, valid_drop);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (rd_addr[i] !== {6'h3C, 3'(i), 3'b000} || rd_cyc[i] !== 1 + 3 * i) begin
        tests_failed++;
        $display("FAIL toggle_read%0d: got %h cyc %0d expected %h cyc %0d", i, rd_addr[i],
                 rd_cyc[i], {6'h3C, 3'(i), 3'b000}, 1 + 3 * i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (bt_data[i] !== exp_beat(8'h08, 6'h3C, i) || bt_beat[i] !== 3'(i)) begin
        tests_failed++;
        $display("FAIL toggle_beat%0d: got %h/%0d expected %h/%0d", i, bt_data[i], bt_beat[i],
                 exp_beat(8'h08, 6'h3C, i), i);
      end
    end
  endtask

  task automatic test_back_to_back();
    stream_line(8'h01, 6'h2A, 0, 0, 0, 1'b0, 1'b1, 8'h80, 6'h3F);
    tests_run++;
    if (n_bt !== 8 || early_accept !== 0 || ready_at_last !== 1'b0 || ready_after !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_accept: got beats %0d early %0d last %b after %b expected 8 0 0 1",
               n_bt, early_accept, ready_at_last, ready_after);
    end
    stream_line(8'h80, 6'h3F, 0, 0, 0, 1'b1, 1'b0, 8'h00, 6'h00);
    tests_run++;
    if (req_acc !== 1'b1 || n_rd !== 8 || rd_way[0] !== 8'h80) begin
      tests_failed++;
      $display("FAIL b2b_second: got acc %b reads %0d way %h expected 1 8 80", req_acc, n_rd,
               rd_way[0]);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (rd_addr[i] !== {6'h3F, 3'(i), 3'b000} || bt_data[i] !== exp_beat(8'h80, 6'h3F, i) ||
          bt_beat[i] !== 3'(i)) begin
        tests_failed++;
        $display("FAIL b2b_beat%0d: got addr %h data %h idx %0d expected %h %h %0d", i,
                 rd_addr[i], bt_data[i], bt_beat[i], {6'h3F, 3'(i), 3'b000},
                 exp_beat(8'h80, 6'h3F, i), i);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    int nr;
    int spurious;
    k = 0; nr = 0; spurious = 0;
    @(negedge clk);
    req_valid = 1'b1; req_way = 8'h10; req_idx = 6'h05; read_ready = 1'b1; beat_ready = 1'b0;
    while (nr < 3 && k < 20) begin
      #1;
      if (read_valid && read_ready) nr++;
      @(negedge clk);
      k++;
      req_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (read_valid !== 1'b0 || beat_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got rv %b bv %b busy %b rr %b expected 0 0 0 0",
               read_valid, beat_valid, busy, req_ready);
    end
    rst_n = 1'b1; beat_ready = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL midreset_req_ready: got %b expected 1", req_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (beat_valid || read_valid) spurious++;
    end
    tests_run++;
    if (spurious !== 0) begin
      tests_failed++; $display("FAIL midreset_late_resp: got %0d spurious expected 0", spurious);
    end
    stream_line(8'h20, 6'h33, 0, 0, 0, 1'b0, 1'b0, 8'h00, 6'h00);
    tests_run++;
    if (n_bt !== 8 || n_rd !== 8) begin
      tests_failed++;
      $display("FAIL midreset_fresh_counts: got %0d reads %0d beats expected 8 8", n_rd, n_bt);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (bt_data[i] !== exp_beat(8'h20, 6'h33, i) || bt_beat[i] !== 3'(i) ||
          bt_last[i] !== (i == 7)) begin
        tests_failed++;
        $display("FAIL midreset_beat%0d: got %h/%0d/%b expected %h/%0d/%b", i, bt_data[i],
                 bt_beat[i], bt_last[i], exp_beat(8'h20, 6'h33, i), i, (i == 7));
      end
    end
  endtask

  task automatic test_way_zero();
    stream_line(8'h00, 6'h07, 0, 0, 0, 1'b0, 1'b0, 8'h00, 6'h00);
    tests_run++;
    if (n_bt !== 8) begin
      tests_failed++; $display("FAIL wayzero_count: got %0d expected 8", n_bt);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (bt_data[i] !== 64'h0 || bt_beat[i] !== 3'(i) || bt_last[i] !== (i == 7)) begin
        tests_failed++;
        $display("FAIL wayzero_beat%0d: got %h/%0d/%b expected 0/%0d/%b", i, bt_data[i],
                 bt_beat[i], bt_last[i], i, (i == 7));
      end
    end
  endtask

  task automatic test_multi_hot();
    stream_line(8'h03, 6'h11, 0, 0, 0, 1'b0, 1'b0, 8'h00, 6'h00);
    tests_run++;
    if (n_bt !== 8) begin
      tests_failed++; $display("FAIL multihot_count: got %0d expected 8", n_bt);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (bt_data[i] !== (way_data(0, {6'h11, 3'(i), 3'b000}) |
                          way_data(1, {6'h11, 3'(i), 3'b000})) || bt_beat[i] !== 3'(i)) begin
        tests_failed++;
        $display("FAIL multihot_beat%0d: got %h/%0d expected %h/%0d", i, bt_data[i], bt_beat[i],
                 way_data(0, {6'h11, 3'(i), 3'b000}) | way_data(1, {6'h11, 3'(i), 3'b000}), i);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_read_toggle();
    test_back_to_back();
    test_reset_mid();
    test_way_zero();
    test_multi_hot();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/boom_dcache_line_reader.md
# boom_dcache_line_reader

Reads one full 64-byte cache line out of the BOOM L1 data array (8 ways × 512 × 64-bit, 2-cycle registered read response) and streams it as eight 64-bit beats over a valid/ready interface. It sits between the writeback/probe unit and the data-array read arbiter. It issues one array read per beat and tracks the fixed array latency. A credit-managed buffer absorbs array responses, which cannot be stalled, while the downstream consumer applies backpressure.

## Interface
Parameters:
- WAYS, 8, number of ways; width of all way_en fields
- BEATS, 8, 64-bit beats per line; beat index width is log2(BEATS)
- READ_LATENCY, 2, cycles from array read handshake to valid data on io_data_resp
- BUF_DEPTH, 4, beat buffer entries; also the maximum outstanding reads plus buffered beats

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low
- io_req_valid  in  1  line read request
- io_req_ready  out  1  request accepted when valid&&ready
- io_req_bits_way_en  in  WAYS  one-hot way select
- io_req_bits_idx  in  6  set index (line address bits [11:6])
- io_data_read_valid  out  1  array read request to arbiter
- io_data_read_ready  in  1  arbiter grant
- io_data_read_bits_way_en  out  WAYS  latched way_en
- io_data_read_bits_addr  out  12  {idx, beat[2:0], 3'b000}
- io_data_resp  in  64*WAYS  array responses, way w at bits [64w+63:64w]
- io_beat_valid  out  1  beat available
- io_beat_ready  in  1  consumer accepts beat
- io_beat_bits_data  out  64  beat data
- io_beat_bits_beat  out  3  beat index 0..7
- io_beat_bits_last  out  1  high on beat 7
- io_busy  out  1  state != IDLE

## Operation
- States:
  - IDLE: io_req_ready=1. On request fire, latch way_en and idx, clear issue counter, go to ISSUE.
  - ISSUE: io_data_read_valid = (credits_used < BUF_DEPTH). On read fire, the issue counter increments. The fire of beat BEATS-1 moves the block to DRAIN.
  - DRAIN: no reads are issued. The fire of the beat with last=1 returns the block to IDLE.
- io_req_ready is 0 outside IDLE. A new request is accepted no earlier than the cycle after the last beat fires.
- Read request:
  - io_data_read_valid does not depend on io_data_read_ready.
  - Once valid is high, addr and way_en hold stable until fire.
  - Valid deasserts only when credits run out; it never deasserts while addr changes.
- Response pipeline: a READ_LATENCY-deep shift register of {valid, beat index}, loaded on read fire.
  - At its output, the block captures data = OR over w of (way_en[w] ? resp_w : 0) into the buffer tail.
  - With one-hot way_en, this selects that way's response.
  - way_en=0 yields zero data. Multi-hot way_en yields the bitwise OR of the selected ways; the beat count is unchanged.
- Credits:
  - credits_used (register, 0..BUF_DEPTH) += read fire, -= beat fire, both applied together on the same edge.
  - The buffer therefore never overflows and never drops a response.
- Beat buffer: a BUF_DEPTH-entry FIFO with no bypass.
  - io_beat_* come from the head and stay stable while valid && !ready.
  - Beats emerge in order 0..7, exactly once each.
- Reset low at an edge:
  - State goes to IDLE; counters, credits, pipeline valids and FIFO clear.
  - Responses for reads issued before reset are discarded.
  - io_req_ready is forced 0 while reset is low.

## Timing
- Reset values, in the cycle after a reset edge: io_data_read_valid=0, io_beat_valid=0, io_busy=0, io_req_ready=0 while reset is low and 1 once it is high.
- Request fire at cycle t:
  - First read valid at t+1.
  - Read fire at cycle r: the response is sampled at r+READ_LATENCY and the beat is valid at r+READ_LATENCY+1.
  - With both readies held high: reads fire t+1..t+8, beats fire t+4..t+11, and io_req_ready returns at t+12.
- Full throughput, one beat per cycle, requires BUF_DEPTH ≥ READ_LATENCY+2. A credit freed by a beat fire is usable by the next cycle's read.
- Simultaneous read fire and beat fire in one cycle leave credits_used unchanged.

## Test plan
- way_en=0x04, idx=0x15, all readies high:
  - Read addrs are 0x540, 0x548, …, 0x578 on 8 consecutive cycles.
  - Beats are way-2 model data with beat index 0..7 and last only on 7.
  - The first beat is 3 cycles after the first read fire; io_req_ready is back 12 cycles after the request.
- io_beat_ready=0 from the start:
  - Exactly 4 reads fire, then io_data_read_valid=0; 4 beats are held with stable data.
  - Release ready: the remaining 4 reads issue and all 8 beats arrive in order.
- io_data_read_ready toggling 1,0,0,1,…: addr holds across the denied cycles, with no skipped or duplicated beat index; total 8 reads.
- Two requests back-to-back, second held valid: the second is accepted exactly 1 cycle after the first's last beat fires, and its reads use the new idx and way.
- Reset low for 1 cycle after 3 reads fire:
  - All valids go 0 next cycle, and late array responses produce no beats.
  - A fresh request then yields a correct 8-beat line.
- way_en=0x00: 8 beats of 64'h0, indices 0..7, last on 7. Also way_en=0x03: beats equal way0|way1 data.
